// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor: state encoding and counter sizing.
package pll_sup_pkg;

  localparam int STATE_W = 3;

  localparam logic [STATE_W-1:0] ST_HOLD_RST  = 3'd0;
  localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
  localparam logic [STATE_W-1:0] ST_STABILIZE = 3'd2;
  localparam logic [STATE_W-1:0] ST_RUN       = 3'd3;
  localparam logic [STATE_W-1:0] ST_FAIL      = 3'd4;

  // One spare bit above the largest timing parameter keeps terminal compares unambiguous.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-high reset.
module sync_2ff #(
  parameter int W = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Brings up the PLL from the reference clock, qualifies LOCK, and gates the
// 60 MHz domain reset; retries on timeout and re-acquires on lock loss.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RESET_CYCLES  = 10,
  parameter int LOCK_TIMEOUT  = 1000,
  parameter int STABLE_CYCLES = 64,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 8
) (
  input  logic               clock_in,
  input  logic               reset,
  input  logic               locked,
  input  logic               force_relock,
  output logic               pll_resetb,
  output logic               sys_reset,
  output logic               ready,
  output logic               failed,
  output logic [CNT_W-1:0]   retry_count,
  output logic [CNT_W-1:0]   loss_count,
  output logic [STATE_W-1:0] state
);

  localparam int CW = cnt_width(RESET_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

  localparam logic [CW-1:0]    RST_LAST  = CW'(RESET_CYCLES - 1);
  localparam logic [CW-1:0]    TMO_LAST  = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0]    STB_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RETRY_MAX = CNT_W'(MAX_RETRIES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                 lock_s;
  logic [STATE_W-1:0]   state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]     retry_q, retry_d;
  logic [CNT_W-1:0]     loss_q, loss_d;
  logic                 pll_resetb_q, sys_reset_q, ready_q, failed_q;

  sync_2ff #(.W(1)) u_lock_sync (
    .clk_i (clock_in),
    .rst_i (reset),
    .d_i   (locked),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      ST_HOLD_RST: begin
        if (force_relock) begin
          cnt_d = '0;
        end else if (cnt_q == RST_LAST) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_WAIT_LOCK: begin
        // Lock takes priority over a coincident timeout.
        if (force_relock) begin
          state_d = ST_HOLD_RST;
          cnt_d   = '0;
        end else if (lock_s) begin
          state_d = ST_STABILIZE;
          cnt_d   = '0;
        end else if (cnt_q == TMO_LAST) begin
          cnt_d = '0;
          if (retry_q == RETRY_MAX) begin
            state_d = ST_FAIL;
          end else begin
            state_d = ST_HOLD_RST;
            retry_d = sat_inc(retry_q);
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STABILIZE: begin
        if (force_relock) begin
          state_d = ST_HOLD_RST;
          cnt_d   = '0;
        end else if (!lock_s) begin
          state_d = ST_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STB_LAST) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RUN: begin
        // A lock drop coinciding with force_relock is still counted once.
        if (!lock_s) begin
          loss_d  = sat_inc(loss_q);
          state_d = ST_HOLD_RST;
          cnt_d   = '0;
        end else if (force_relock) begin
          state_d = ST_HOLD_RST;
          cnt_d   = '0;
        end
      end
      ST_FAIL: begin
        if (force_relock) begin
          state_d = ST_HOLD_RST;
          cnt_d   = '0;
          retry_d = '0;
        end
      end
      default: begin
        state_d = ST_HOLD_RST;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clock_in or posedge reset) begin
    if (reset) begin
      state_q      <= ST_HOLD_RST;
      cnt_q        <= '0;
      retry_q      <= '0;
      loss_q       <= '0;
      pll_resetb_q <= 1'b0;
      sys_reset_q  <= 1'b1;
      ready_q      <= 1'b0;
      failed_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      retry_q      <= retry_d;
      loss_q       <= loss_d;
      // Outputs decode the next state so they change on the same edge as the state.
      pll_resetb_q <= (state_d == ST_WAIT_LOCK) || (state_d == ST_STABILIZE) ||
                      (state_d == ST_RUN);
      sys_reset_q  <= (state_d != ST_RUN);
      ready_q      <= (state_d == ST_RUN);
      failed_q     <= (state_d == ST_FAIL);
    end
  end

  assign pll_resetb  = pll_resetb_q;
  assign sys_reset   = sys_reset_q;
  assign ready       = ready_q;
  assign failed      = failed_q;
  assign retry_count = retry_q;
  assign loss_count  = loss_q;
  assign state       = state_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sequences bring-up of the 10→60 MHz SB_PLL40_CORE wrapper.
- Drives the PLL RESETB, qualifies its LOCK output, and produces the reset/ready for logic on the 60 MHz clock.
- Runs entirely on the 10 MHz reference clock (the PLL output is untrusted before lock).
- Retries acquisition on timeout, re-acquires on lock loss, and exposes health counters to the host register map.

Parameters:
RESET_CYCLES, 10, cycles pll_resetb held low per reset attempt (1 us at 10 MHz)
LOCK_TIMEOUT, 1000, cycles allowed in WAIT_LOCK before a retry (100 us)
STABLE_CYCLES, 64, consecutive synchronized-lock-high cycles required before RUN
MAX_RETRIES, 3, timeout retries per acquisition before FAIL
CNT_W, 8, width of the saturating retry/loss counters

Ports:
clock_in  input  1  10 MHz reference clock, same net as the PLL REFERENCECLK
reset  input  1  asynchronous, active-high reset
locked  input  1  PLL LOCK, asynchronous to clock_in
force_relock  input  1  single-cycle request to restart acquisition; also clears FAIL
pll_resetb  output  1  to PLL RESETB, active low
sys_reset  output  1  active-high reset for the 60 MHz domain; the consumer synchronizes deassertion
ready  output  1  high only in RUN
failed  output  1  high only in FAIL
retry_count  output  CNT_W  timeout retries in the current acquisition, saturating
loss_count  output  CNT_W  lock-loss events since reset, saturating, never auto-cleared
state  output  3  encoded FSM state for debug/status

Behaviour:
- Reset (async assert, clock_in-synchronous release):
  - state=HOLD_RST, pll_resetb=0, sys_reset=1, ready=0, failed=0.
  - retry_count=0, loss_count=0; cycle counter and sync flops cleared.
- All outputs are registered; the counter width is $clog2 of the largest timing parameter plus 1.
- locked passes through a 2-flop synchronizer to give lock_s (2-cycle latency); the FSM uses only lock_s.
- State encoding (package): HOLD_RST=0, WAIT_LOCK=1, STABILIZE=2, RUN=3, FAIL=4.
- HOLD_RST: pll_resetb=0, sys_reset=1.
  - Counter runs 0..RESET_CYCLES-1, then the FSM moves to WAIT_LOCK with the counter cleared.
  - pll_resetb is exactly RESET_CYCLES cycles low per attempt.
- WAIT_LOCK: pll_resetb=1.
  - lock_s=1 → STABILIZE, counter cleared.
  - Counter reaches LOCK_TIMEOUT-1 with lock_s=0:
    - retry_count==MAX_RETRIES → FAIL;
    - otherwise retry_count++ and → HOLD_RST.
- STABILIZE: counter increments while lock_s=1.
  - lock_s=0 → WAIT_LOCK with the counter cleared (a fresh timeout; this is not a retry).
  - Counter reaches STABLE_CYCLES-1 → RUN.
- RUN: sys_reset=0 and ready=1, registered the cycle RUN is entered.
  - retry_count clears on entry.
  - lock_s=0 → sys_reset=1 and ready=0 on the next edge, loss_count++ (saturating at 2^CNT_W-1), → HOLD_RST.
- FAIL: pll_resetb=0, sys_reset=1, failed=1.
  - Sticky; exits only via reset or force_relock.
  - force_relock → HOLD_RST with retry_count=0.
- force_relock in WAIT_LOCK/STABILIZE/RUN → HOLD_RST, counter cleared, retry_count unchanged.
  - In RUN, sys_reset asserts next edge; no loss counted unless lock_s=0 in the same cycle (then count once).
- force_relock in HOLD_RST: restarts the RESET_CYCLES count.
- Simultaneous timeout and lock_s rising in WAIT_LOCK: lock wins (→ STABILIZE).
- Counters saturate and never wrap. sys_reset is never 0 outside RUN.

Decomposition:
- Package pll_sup_pkg: state enum, state width, and the counter-width function.
- Sub-module sync_2ff: a generic 2-flop synchronizer with async reset, reusable for other cross-domain status bits.
- Everything else stays in one FSM module.

Test Plan:
Bench parameters: RESET_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2.
1. Clean bring-up: locked rises 3 cycles after pll_resetb rises → pll_resetb low exactly 4 cycles; ready=1 and sys_reset=0 on the cycle 2(sync)+1+8 after locked; retry_count=0.
2. Single timeout: locked held 0 for 20 cycles, then rises on the next attempt → retry_count=1, second 4-cycle pll_resetb pulse, then RUN with retry_count cleared to 0.
3. Exhaustion: locked stuck 0 → 3 reset pulses total, then failed=1, state=4, pll_resetb=0, sys_reset=1; force_relock pulse → HOLD_RST, failed=0, retry_count=0.
4. Lock glitch in STABILIZE: locked drops for 1 cycle after 5 stable cycles → returns to WAIT_LOCK, no retry counted, and RUN needs 8 fresh stable cycles.
5. Lock loss in RUN: locked drops → sys_reset=1 within 3 edges, loss_count=1, reacquires to RUN; repeat 300 times → loss_count saturates at 255.
6. Reset mid-STABILIZE: assert reset asynchronously → outputs take reset values immediately without a clock edge; loss_count=0 after release.
